// File: rtl/vga_pix_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_pix_pkg
//  Purpose  : Shared constants and the colour width-expansion helper for the
//             VGA pixel output stage.
//  Revision : 1.0  initial release
// ============================================================================
package vga_pix_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  localparam int DEF_CW   = 3;
  localparam int DEF_IN_W = 1;
  localparam int DEF_LAT  = 0;
  localparam int DEF_FCW  = 16;

  // Expand an in_w-bit channel value (right-aligned in v) to 8 bits by
  // repeating its bits MSB first; callers keep the top CW bits.
  function automatic logic [7:0] expand_rep(input logic [7:0] v, input int in_w);
    logic [7:0] r;
    logic [2:0] src;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      src = 3'(in_w - 1 - (i % in_w));
      r[3'(7 - i)] = v[src];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_pix_out_if.sv
`default_nettype none
// ============================================================================
//  Module   : vga_pix_out_if
//  Purpose  : Bundles the sync-generator timing, the graphics colour and the
//             aligned VGA outputs. Optional test-pattern inputs appear only
//             when VGA_PIX_TPAT_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
interface vga_pix_out_if
  import vga_pix_pkg::*;
#(
  parameter int CW   = DEF_CW,
  parameter int IN_W = DEF_IN_W,
  parameter int FCW  = DEF_FCW
);
  logic              p_tick;
  logic              video_on;
  logic              hsync_in;
  logic              vsync_in;
  logic [3*IN_W-1:0] graph_rgb;
`ifdef VGA_PIX_TPAT_EN
  logic              tpat_sel;
  logic [9:7]        pixel_x;
`endif
  logic              hsync;
  logic              vsync;
  logic [CW-1:0]     red;
  logic [CW-1:0]     green;
  logic [CW-1:0]     blue;
  logic              frame_tick;
  logic [FCW-1:0]    frame_cnt;

  // Source side: sync generator plus graphics generator.
  modport master (
`ifdef VGA_PIX_TPAT_EN
    output tpat_sel, pixel_x,
`endif
    output p_tick, video_on, hsync_in, vsync_in, graph_rgb,
    input  hsync, vsync, red, green, blue, frame_tick, frame_cnt
  );

  // Sink side: the pixel output stage.
  modport slave (
`ifdef VGA_PIX_TPAT_EN
    input  tpat_sel, pixel_x,
`endif
    input  p_tick, video_on, hsync_in, vsync_in, graph_rgb,
    output hsync, vsync, red, green, blue, frame_tick, frame_cnt
  );
endinterface
`default_nettype wire

// File: rtl/vga_dly_line.sv
`default_nettype none
// ============================================================================
//  Module   : vga_dly_line
//  Purpose  : Enable-gated shift register of DEPTH stages, WIDTH bits each,
//             asynchronously cleared. dout_next is the value the last stage
//             loads on the next enabled edge (used for edge detection).
//  Revision : 1.0  initial release
// ============================================================================
module vga_dly_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] dout_next
);
  logic [WIDTH-1:0] stage [DEPTH];

  // Shift one position per enabled clock; reset empties every stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (en) begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

  generate
    if (DEPTH == 1) begin : g_next_din
      assign dout_next = din;
    end else begin : g_next_stage
      assign dout_next = stage[DEPTH-2];
    end
  endgenerate
endmodule
`default_nettype wire

// File: rtl/vga_pix_out.sv
`default_nettype none
// ============================================================================
//  Module   : vga_pix_out
//  Purpose  : VGA pixel output stage. Delays sync/blank timing by LAT+1 pixel
//             ticks to match the graphics generator, registers and expands
//             colour, blanks outside the active area, counts frames.
//             Optional colour-bar test pattern: define VGA_PIX_TPAT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module vga_pix_out
  import vga_pix_pkg::*;
#(
  parameter int CW   = DEF_CW,
  parameter int IN_W = DEF_IN_W,
  parameter int LAT  = DEF_LAT,
  parameter int FCW  = DEF_FCW
) (
  input  logic          clk,
  input  logic          reset_n,
  vga_pix_out_if.slave  bus
);
  localparam int DEPTH = LAT + 1;

  logic [2:0] tim_d;
  logic [2:0] tim_next;
  logic       unused_tim_next;
  logic       vid_d;

  // Timing bits {video_on, hsync, vsync} share one delay line so they stay aligned.
  vga_dly_line #(.WIDTH(3), .DEPTH(DEPTH)) u_tim_dly (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (bus.p_tick),
    .din       ({bus.video_on, bus.hsync_in, bus.vsync_in}),
    .dout      (tim_d),
    .dout_next (tim_next)
  );
  assign unused_tim_next = ^tim_next[2:1];
  assign vid_d           = tim_d[2];

  // Generator colour already lags timing by LAT; one more stage lines it up.
  logic [3*IN_W-1:0] rgb_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        rgb_q <= '0;
    else if (bus.p_tick) rgb_q <= bus.graph_rgb;
  end

  logic [7:0] red_x, green_x, blue_x;
  assign red_x   = expand_rep(8'(rgb_q[IN_W-1:0]),        IN_W);
  assign green_x = expand_rep(8'(rgb_q[2*IN_W-1:IN_W]),   IN_W);
  assign blue_x  = expand_rep(8'(rgb_q[3*IN_W-1:2*IN_W]), IN_W);

  logic [CW-1:0] red_s, green_s, blue_s;

`ifdef VGA_PIX_TPAT_EN
  logic [2:0] px_d;
  logic [2:0] unused_px_next;
  logic       tpat_q;

  // Bar index follows the same delay as the timing it is drawn against.
  vga_dly_line #(.WIDTH(3), .DEPTH(DEPTH)) u_px_dly (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (bus.p_tick),
    .din       (bus.pixel_x),
    .dout      (px_d),
    .dout_next (unused_px_next)
  );

  // Pattern select is sampled per pixel so outputs hold between ticks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        tpat_q <= 1'b0;
    else if (bus.p_tick) tpat_q <= bus.tpat_sel;
  end

  // Colour source: generator data, or full-scale bars indexed {B,G,R}.
  always_comb begin
    red_s   = red_x[7 -: CW];
    green_s = green_x[7 -: CW];
    blue_s  = blue_x[7 -: CW];
    if (tpat_q) begin
      red_s   = {CW{px_d[0]}};
      green_s = {CW{px_d[1]}};
      blue_s  = {CW{px_d[2]}};
    end
  end
`else
  assign red_s   = red_x[7 -: CW];
  assign green_s = green_x[7 -: CW];
  assign blue_s  = blue_x[7 -: CW];
`endif

  assign bus.red   = vid_d ? red_s   : '0;
  assign bus.green = vid_d ? green_s : '0;
  assign bus.blue  = vid_d ? blue_s  : '0;
  assign bus.hsync = tim_d[1];
  assign bus.vsync = tim_d[0];

  logic           frame_tick_q;
  logic [FCW-1:0] frame_cnt_q;

  // Frame start: the delayed vsync is about to rise on this pixel tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_tick_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      frame_tick_q <= 1'b0;
      if (bus.p_tick && tim_next[0] && !tim_d[0]) begin
        frame_tick_q <= 1'b1;
        frame_cnt_q  <= frame_cnt_q + FCW'(1);
      end
    end
  end

  assign bus.frame_tick = frame_tick_q;
  assign bus.frame_cnt  = frame_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_vga_pix_out.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_pix_out
//  Purpose  : Self-checking bench for vga_pix_out. Two instances run the same
//             timing: A (IN_W=1, LAT=0, FCW=2) and B (IN_W=2, LAT=3, FCW=16).
//             Expected timing is queued per pixel and popped as it emerges.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_pix_out;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  vga_pix_out_if #(.CW(3), .IN_W(1), .FCW(2))  ia ();
  vga_pix_out_if #(.CW(3), .IN_W(2), .FCW(16)) ib ();

  vga_pix_out #(.CW(3), .IN_W(1), .LAT(0), .FCW(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ia.slave)
  );
  vga_pix_out #(.CW(3), .IN_W(2), .LAT(LAT_B), .FCW(16)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ib.slave)
  );

  typedef struct packed { logic vid; logic hs; logic vs; } tim_t;
  tim_t qa[$];
  tim_t qb[$];

  int checks = 0;
  int errors = 0;
  int step   = 0;

  logic       last_vs_a, last_vs_b;
  int         cnt_a, cnt_b;
  logic       lh_a, lv_a, lh_b, lv_b;
  logic [2:0] lr_a, lr_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step, obs, exp);
    end
  endtask

  task automatic set_in(input logic vid, input logic hs, input logic vs,
                        input logic [2:0] ra, input logic [5:0] rb);
    ia.video_on = vid; ia.hsync_in = hs; ia.vsync_in = vs; ia.graph_rgb = ra;
    ib.video_on = vid; ib.hsync_in = hs; ib.vsync_in = vs; ib.graph_rgb = rb;
  endtask

  task automatic model_reset();
    tim_t z;
    z = '0;
    qa.delete();
    qb.delete();
    for (int i = 0; i < LAT_B; i++) qb.push_back(z);
    last_vs_a = 1'b0; last_vs_b = 1'b0;
    cnt_a = 0; cnt_b = 0;
    lh_a = 1'b0; lv_a = 1'b0; lh_b = 1'b0; lv_b = 1'b0;
    lr_a = 3'b000; lr_b = 3'b000;
  endtask

  task automatic check_zero();
    chk("a_hsync", 32'(ia.hsync), 32'd0);  chk("b_hsync", 32'(ib.hsync), 32'd0);
    chk("a_vsync", 32'(ia.vsync), 32'd0);  chk("b_vsync", 32'(ib.vsync), 32'd0);
    chk("a_red",   32'(ia.red),   32'd0);  chk("b_red",   32'(ib.red),   32'd0);
    chk("a_green", 32'(ia.green), 32'd0);  chk("b_green", 32'(ib.green), 32'd0);
    chk("a_blue",  32'(ia.blue),  32'd0);  chk("b_blue",  32'(ib.blue),  32'd0);
    chk("a_ftick", 32'(ia.frame_tick), 32'd0); chk("b_ftick", 32'(ib.frame_tick), 32'd0);
    chk("a_fcnt",  32'(ia.frame_cnt),  32'd0); chk("b_fcnt",  32'(ib.frame_cnt),  32'd0);
  endtask

  // One pixel: optional idle gap with scrambled inputs (outputs must hold),
  // then a single p_tick carrying the real inputs, then compare.
  task automatic drive(input logic vid, input logic hs, input logic vs,
                       input logic [2:0] ra, input logic [5:0] rb, input int gap);
    tim_t t, ea, eb;
    logic fa, fb;
    logic [2:0] eg_a, eb_a, eg_b, ebl_b;
    step++;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      set_in(1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), 6'($urandom));
    end
    if (gap > 0) begin
      @(negedge clk);
      chk("a_hold_hs",  32'(ia.hsync), 32'(lh_a));  chk("b_hold_hs",  32'(ib.hsync), 32'(lh_b));
      chk("a_hold_vs",  32'(ia.vsync), 32'(lv_a));  chk("b_hold_vs",  32'(ib.vsync), 32'(lv_b));
      chk("a_hold_red", 32'(ia.red),   32'(lr_a));  chk("b_hold_red", 32'(ib.red),   32'(lr_b));
      chk("a_hold_ft",  32'(ia.frame_tick), 32'd0); chk("b_hold_ft",  32'(ib.frame_tick), 32'd0);
      chk("a_hold_cnt", 32'(ia.frame_cnt), 32'(cnt_a));
      chk("b_hold_cnt", 32'(ib.frame_cnt), 32'(cnt_b));
    end
    set_in(vid, hs, vs, ra, rb);
    t.vid = vid; t.hs = hs; t.vs = vs;
    qa.push_back(t);
    qb.push_back(t);
    ia.p_tick = 1'b1; ib.p_tick = 1'b1;
    @(negedge clk);
    ia.p_tick = 1'b0; ib.p_tick = 1'b0;

    ea = qa.pop_front();
    fa = ea.vs & ~last_vs_a;
    if (fa) cnt_a = (cnt_a + 1) % 4;
    last_vs_a = ea.vs;
    lh_a = ea.hs; lv_a = ea.vs;
    lr_a = ea.vid ? {3{ra[0]}} : 3'b000;
    eg_a = ea.vid ? {3{ra[1]}} : 3'b000;
    eb_a = ea.vid ? {3{ra[2]}} : 3'b000;
    chk("a_hsync", 32'(ia.hsync), 32'(lh_a));
    chk("a_vsync", 32'(ia.vsync), 32'(lv_a));
    chk("a_red",   32'(ia.red),   32'(lr_a));
    chk("a_green", 32'(ia.green), 32'(eg_a));
    chk("a_blue",  32'(ia.blue),  32'(eb_a));
    chk("a_ftick", 32'(ia.frame_tick), 32'(fa));
    chk("a_fcnt",  32'(ia.frame_cnt),  32'(cnt_a));

    eb = qb.pop_front();
    fb = eb.vs & ~last_vs_b;
    if (fb) cnt_b = (cnt_b + 1) % 65536;
    last_vs_b = eb.vs;
    lh_b = eb.hs; lv_b = eb.vs;
    lr_b  = eb.vid ? {rb[1:0], rb[1]} : 3'b000;
    eg_b  = eb.vid ? {rb[3:2], rb[3]} : 3'b000;
    ebl_b = eb.vid ? {rb[5:4], rb[5]} : 3'b000;
    chk("b_hsync", 32'(ib.hsync), 32'(lh_b));
    chk("b_vsync", 32'(ib.vsync), 32'(lv_b));
    chk("b_red",   32'(ib.red),   32'(lr_b));
    chk("b_green", 32'(ib.green), 32'(eg_b));
    chk("b_blue",  32'(ib.blue),  32'(ebl_b));
    chk("b_ftick", 32'(ib.frame_tick), 32'(fb));
    chk("b_fcnt",  32'(ib.frame_cnt),  32'(cnt_b));
  endtask

  initial begin
    reset_n = 1'b1;
    ia.p_tick = 1'b0; ib.p_tick = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 3'b000, 6'b000000);
`ifdef VGA_PIX_TPAT_EN
    ia.tpat_sel = 1'b0; ib.tpat_sel = 1'b0;
    ia.pixel_x  = 3'b000; ib.pixel_x = 3'b000;
`endif
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_zero();
    reset_n = 1'b1;
    model_reset();

    // Active video: A red=1 green=0 blue=1; B red=10 green=01 blue=11.
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 1'b0, 3'b101, 6'b110110, i % 3);

    // Single-pixel hsync pulse, with idle gaps between pixel ticks.
    drive(1'b1, 1'b1, 1'b0, 3'b101, 6'b110110, 1);
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 1'b0, 3'b011, 6'b011011, 2);

    // Blanking with full-scale colour on the input.
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0, 3'b111, 6'b111111, 0);

    // Five frames: A's two-bit counter wraps 1,2,3,0,1.
    for (int f = 0; f < 5; f++) begin
      drive(1'b0, 1'b0, 1'b1, 3'b000, 6'b000000, 0);
      drive(1'b0, 1'b0, 1'b1, 3'b000, 6'b000000, 1);
      drive(1'b0, 1'b0, 1'b0, 3'b000, 6'b000000, 0);
      drive(1'b0, 1'b0, 1'b0, 3'b000, 6'b000000, 0);
    end
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, 3'b000, 6'b000000, 0);

    // Mixed random pixels.
    for (int i = 0; i < 24; i++)
      drive(1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), 6'($urandom),
            int'($urandom_range(2)));

    // Reset mid-line with video active: outputs clear without a clock edge.
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, 3'b110, 6'b100111, 0);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_zero();
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();

    // vsync already high at release: the cleared stage still yields a frame tick.
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 1'b1, 3'b001, 6'b000110, 0);
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 1'b0, 3'b010, 6'b101001, 1);

`ifdef VGA_PIX_TPAT_EN
    // Colour bars: pixel_x in 128..255 selects the red bar.
    ia.tpat_sel = 1'b1; ib.tpat_sel = 1'b1;
    ia.pixel_x  = 3'b001; ib.pixel_x = 3'b001;
    set_in(1'b1, 1'b0, 1'b0, 3'b110, 6'b111100);
    for (int i = 0; i < 5; i++) begin
      ia.p_tick = 1'b1; ib.p_tick = 1'b1;
      @(negedge clk);
      ia.p_tick = 1'b0; ib.p_tick = 1'b0;
    end
    step++;
    chk("a_tp_red",   32'(ia.red),   32'h7); chk("b_tp_red",   32'(ib.red),   32'h7);
    chk("a_tp_green", 32'(ia.green), 32'h0); chk("b_tp_green", 32'(ib.green), 32'h0);
    chk("a_tp_blue",  32'(ia.blue),  32'h0); chk("b_tp_blue",  32'(ib.blue),  32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/vga_pix_out.md
VGA_PIX_OUT -- requirements
Module: vga_pix_out

Interface
REQ-001 Parameter CW, default 3, output colour bits per channel (1..8).
REQ-002 Parameter IN_W, default 1, input colour bits per channel from the graphics generator (1..CW).
REQ-003 Parameter LAT, default 0, graphics-generator latency in pixel ticks (0..7).
REQ-004 Parameter FCW, default 16, frame counter width.
REQ-005 clk  input  1  system clock; all state SHALL be clocked on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 p_tick  input  1  pixel enable from the VGA sync generator, one clk wide.
REQ-008 video_on, hsync_in, vsync_in  input  1 each  timing from the VGA sync generator; sync pulses are active-high.
REQ-009 graph_rgb  input  3*IN_W  generator colour, packed {blue, green, red}, each IN_W bits.
REQ-010 hsync, vsync  output  1 each  timing-aligned sync outputs.
REQ-011 red, green, blue  output  CW each  blanked, width-expanded colour.
REQ-012 frame_tick  output  1  one-clk pulse at frame start; frame_cnt  output  FCW  frame count.

Function
REQ-013 State SHALL advance only on clk edges where p_tick=1; with p_tick=0, all outputs SHALL hold.
REQ-014 video_on, hsync_in and vsync_in SHALL pass through a delay line of LAT+1 p_tick stages.
REQ-015 graph_rgb SHALL be captured in one register stage per p_tick, so colour and delayed timing refer to the same pixel.
REQ-016 Each channel SHALL expand IN_W to CW bits by MSB-first bit replication, truncated to CW (IN_W=1 → 000/111; IN_W=2, CW=3: 10 → 101).
REQ-017 The red, green and blue outputs SHALL be 0 whenever the delayed video_on is 0.
REQ-018 On a p_tick where the delayed vsync goes 0→1, frame_tick SHALL pulse for exactly that clk.
REQ-019 On that same clk, frame_cnt SHALL increment, wrapping from 2^FCW-1 to 0.
REQ-020 hsync and vsync SHALL be registered outputs with no combinational path from any input.

Reset
REQ-021 reset_n=0 SHALL immediately clear all delay stages, the colour register, hsync, vsync, red, green, blue, frame_tick and frame_cnt to 0.
REQ-022 After reset release, the outputs SHALL stay blank and sync low until LAT+1 p_ticks have refilled the pipeline.
REQ-023 A reset asserted mid-line or mid-frame SHALL need no recovery beyond REQ-022.
REQ-024 A vsync already high at reset release SHALL produce frame_tick once the high value reaches the delayed output, since the stage starts at 0.

Configuration
REQ-025 Macro VGA_PIX_TPAT_EN, when defined, SHALL add input tpat_sel (1 bit) and a pixel_x[9:7] input.
REQ-026 With VGA_PIX_TPAT_EN defined, pixel_x[9:7] SHALL be delayed LAT+1 stages.
REQ-027 With VGA_PIX_TPAT_EN defined and tpat_sel=1, graph_rgb SHALL be replaced by an 8-bar pattern: bar index b={B,G,R} per bit, each channel all-ones or all-zeros, still blanked per REQ-017.
REQ-028 Without VGA_PIX_TPAT_EN, tpat_sel and pixel_x SHALL be absent and no test-pattern logic SHALL be synthesised.

Structure
REQ-029 Shared package vga_pix_pkg SHALL hold: H_ACTIVE=640, V_ACTIVE=480, default CW/IN_W/LAT, and the replication width-expansion function.
REQ-030 Sub-module vga_dly_line SHALL implement the parametrised (WIDTH, DEPTH) enable-gated shift register with asynchronous clear, instantiated for timing and, when configured, for pixel_x bits.

Verification
REQ-031 IN_W=1, CW=3, LAT=0; graph_rgb=3'b101, video_on=1 held → after 1 p_tick red=111, green=000, blue=111.
REQ-032 LAT=3; single-tick hsync_in pulse → hsync high exactly 4 p_ticks later, width 1 p_tick; p_tick gaps do not change the count.
REQ-033 IN_W=2, CW=3; graph_rgb red=10, green=01, blue=11 → red=101, green=010, blue=111; video_on=0 → all 000.
REQ-034 FCW=2; 5 vsync rising edges → frame_tick 5 single-clk pulses, frame_cnt 1,2,3,0,1.
REQ-035 Reset asserted mid-line with video active → all outputs 0 without a clk edge; after release, blank for LAT+1 p_ticks, then the normal stream.
REQ-036 VGA_PIX_TPAT_EN defined, tpat_sel=1, pixel_x=128..255 active → {blue,green,red}=000,000,111.
